// File: rtl/snake_score_beep.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | snake_score_beep                                                       |
// | BCD score / session high score keeper and buzzer pattern generator.    |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module snake_score_beep #(
  parameter int TONE_DIV    = 25000,
  parameter int BURST_CYC   = 5000000,
  parameter int GAP_CYC     = 5000000,
  parameter int OVER_BURSTS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add_cube,
  input  logic [1:0]  game_status,
  output logic [11:0] score_bcd,
  output logic [11:0] hi_bcd,
  output logic        new_record,
  output logic        beep,
  output logic        beep_busy
);

  localparam int c_TMR_MAX = (BURST_CYC > GAP_CYC) ? BURST_CYC : GAP_CYC;
  localparam int c_TW      = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
  localparam int c_DW      = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int c_CW      = $clog2(OVER_BURSTS + 1);

  localparam logic [c_TW-1:0] c_BURST_LAST = c_TW'(BURST_CYC - 1);
  localparam logic [c_TW-1:0] c_GAP_LAST   = c_TW'(GAP_CYC - 1);
  localparam logic [c_DW-1:0] c_DIV_LAST   = c_DW'(TONE_DIV - 1);
  localparam logic [c_CW-1:0] c_BURSTS     = c_CW'(OVER_BURSTS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EAT_TONE  = 2'd1,
    ST_OVER_TONE = 2'd2,
    ST_OVER_GAP  = 2'd3
  } state_t;

  logic        r_add_cube_d;
  logic [1:0]  r_status_d;
  logic [11:0] r_score;
  logic [11:0] r_hi;
  logic        r_new_record;
  logic        w_eat;
  logic        w_over_evt;
  logic        w_start_evt;
  logic [11:0] w_score_inc;

  state_t          r_state, w_state_nxt;
  logic [c_TW-1:0] r_timer, w_timer_nxt;
  logic [c_DW-1:0] r_div,   w_div_nxt;
  logic [c_CW-1:0] r_cnt,   w_cnt_nxt;
  logic            r_beep,  w_beep_nxt;

  assign w_eat       = add_cube & ~r_add_cube_d & (game_status == 2'b10);
  assign w_over_evt  = (game_status == 2'b11) & (r_status_d != 2'b11);
  assign w_start_evt = (game_status == 2'b01) & (r_status_d != 2'b01);

  // Decimal increment, holding at 999.
  always_comb begin
    w_score_inc = r_score;
    if (r_score != 12'h999) begin
      if (r_score[3:0] != 4'd9) begin
        w_score_inc[3:0] = r_score[3:0] + 4'd1;
      end else begin
        w_score_inc[3:0] = 4'd0;
        if (r_score[7:4] != 4'd9) begin
          w_score_inc[7:4] = r_score[7:4] + 4'd1;
        end else begin
          w_score_inc[7:4]  = 4'd0;
          w_score_inc[11:8] = r_score[11:8] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_add_cube_d <= 1'b0;
      r_status_d   <= 2'b00;
      r_score      <= 12'h000;
      r_hi         <= 12'h000;
      r_new_record <= 1'b0;
    end else begin
      r_add_cube_d <= add_cube;
      r_status_d   <= game_status;
      if (w_start_evt) begin
        r_score <= 12'h000;
      end else if (w_eat) begin
        r_score <= w_score_inc;
      end
      // Valid BCD digits order like binary, so a plain unsigned compare is MSD-first.
      if (r_score > r_hi) begin
        r_hi <= r_score;
      end
      if (w_start_evt) begin
        r_new_record <= 1'b0;
      end else if (r_score > r_hi) begin
        r_new_record <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_beep  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_beep  <= w_beep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    w_beep_nxt  = r_beep;
    if (w_start_evt) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
      w_div_nxt   = '0;
      w_cnt_nxt   = '0;
      w_beep_nxt  = 1'b0;
    end else if (w_over_evt) begin
      w_state_nxt = ST_OVER_TONE;
      w_timer_nxt = '0;
      w_div_nxt   = '0;
      w_cnt_nxt   = c_CW'(1);
      w_beep_nxt  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_eat) begin
            w_state_nxt = ST_EAT_TONE;
            w_timer_nxt = '0;
            w_div_nxt   = '0;
            w_beep_nxt  = 1'b1;
          end
        end
        ST_EAT_TONE, ST_OVER_TONE: begin
          if ((r_state == ST_EAT_TONE) && w_eat) begin
            w_timer_nxt = '0;
            w_div_nxt   = '0;
            w_beep_nxt  = 1'b1;
          end else if (r_timer == c_BURST_LAST) begin
            w_state_nxt = ((r_state == ST_EAT_TONE) || (r_cnt == c_BURSTS)) ? ST_IDLE : ST_OVER_GAP;
            w_timer_nxt = '0;
            w_div_nxt   = '0;
            w_beep_nxt  = 1'b0;
          end else begin
            w_timer_nxt = r_timer + c_TW'(1);
            if (r_div == c_DIV_LAST) begin
              w_div_nxt  = '0;
              w_beep_nxt = ~r_beep;
            end else begin
              w_div_nxt = r_div + c_DW'(1);
            end
          end
        end
        ST_OVER_GAP: begin
          if (r_timer == c_GAP_LAST) begin
            w_state_nxt = ST_OVER_TONE;
            w_timer_nxt = '0;
            w_div_nxt   = '0;
            w_cnt_nxt   = r_cnt + c_CW'(1);
            w_beep_nxt  = 1'b1;
          end else begin
            w_timer_nxt = r_timer + c_TW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_beep_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign score_bcd  = r_score;
  assign hi_bcd     = r_hi;
  assign new_record = r_new_record;
  assign beep       = r_beep;
  assign beep_busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/snake_score_beep.md
Name: snake_score_beep

Overview:
- Scoring and audio-feedback stage downstream of the game controller and snake logic.
- Consumes the apple-eaten pulse (add_cube) and game_status.
- Keeps the current score and the session high score as 3-digit BCD for the seven-segment driver.
- Drives the buzzer: a single tone burst per apple, and a three-burst pattern on game over.

Parameters:
- TONE_DIV, 25000, clk cycles per beep half-period (1 kHz at 50 MHz)
- BURST_CYC, 5000000, length in cycles of one tone burst (100 ms)
- GAP_CYC, 5000000, silent gap in cycles between game-over bursts
- OVER_BURSTS, 3, number of bursts in the game-over pattern

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- add_cube  in  1  apple eaten; level or pulse; only its rising edge counts
- game_status  in  2  01 start screen, 10 playing, 11 game over, 00 idle
- score_bcd  out  12  current score, BCD {hundreds, tens, ones}
- hi_bcd  out  12  highest score since rst_n, BCD
- new_record  out  1  high when the current game has raised hi_bcd
- beep  out  1  buzzer square wave
- beep_busy  out  1  high while the beep FSM is not IDLE

Behaviour:
- Reset:
  - Asserting rst_n low immediately clears all outputs and internal registers: scores 0, beep 0, FSM IDLE.
  - Reset mid-burst silences beep at once.
- Edge detect:
  - Register add_cube_d and status_d.
  - eat = add_cube & ~add_cube_d & (game_status==2'b10).
  - over_evt = (game_status==2'b11) & (status_d!=2'b11).
  - start_evt = (game_status==2'b01) & (status_d!=2'b01).
- Score:
  - On eat, score_bcd increments with decimal carry (ones 9 to 0 carries into tens, and so on).
  - Visible one cycle after add_cube first samples high.
  - Saturates at 999: further eats leave it at 999, but still trigger the eat tone.
  - start_evt clears score_bcd and new_record.
  - If start_evt and eat occur in the same cycle, clear wins.
- High score:
  - Registered compare: if score_bcd > hi_bcd (BCD compare, digit-wise from the MSD), then hi_bcd <= score_bcd and new_record <= 1.
  - hi_bcd lags score_bcd by one cycle.
  - hi_bcd is never cleared except by rst_n.
- Beep FSM states: IDLE, EAT_TONE, OVER_TONE, OVER_GAP. Uses a burst timer, a tone divider and a burst counter.
  - IDLE --eat--> EAT_TONE; timer = 0, beep set to 1 on the same edge.
  - EAT_TONE: beep toggles every TONE_DIV cycles. At timer == BURST_CYC-1, go to IDLE and beep = 0. A new eat restarts the timer and tone phase (beep = 1).
  - Any state --over_evt--> OVER_TONE, burst count = 1, beep = 1. Game over pre-empts an eat tone.
  - OVER_TONE: at end of burst, go to OVER_GAP with beep = 0, unless count == OVER_BURSTS, in which case go to IDLE.
  - OVER_GAP: after GAP_CYC cycles, go to OVER_TONE, count+1, beep = 1.
  - eat is ignored in OVER_TONE and OVER_GAP. In those states game_status is 11, so eat cannot occur.
  - start_evt in any state forces IDLE and beep = 0.
- beep is 0 in IDLE and OVER_GAP. beep_busy = (state != IDLE).
- Timers are wide enough for the parameter values. The burst counter holds OVER_BURSTS.

Test Plan (TONE_DIV=4, BURST_CYC=20, GAP_CYC=10, OVER_BURSTS=3):
- Reset, status=10, one add_cube pulse -> score_bcd=0x001 next cycle; hi_bcd=0x001 one cycle later; new_record=1; beep high 4, low 4, high 4, low 4, high 4 cycles, then 0; beep_busy high 20 cycles.
- Hold add_cube high for 50 cycles in play -> score increments by 1 only; 10 separate pulses from 0x009 -> 0x019 (carry check); from 0x999 one pulse -> stays 0x999 and tone still starts.
- Status 10 -> 11 during an eat tone -> beep pattern is 20 on / 10 off / 20 on / 10 off / 20 on, then IDLE; add_cube pulses during the pattern do not change score.
- After game over, status -> 01 -> score_bcd=0, new_record=0, hi_bcd unchanged; next game reaching 0x002 below hi 0x005 -> new_record stays 0.
- add_cube pulses while status=01 or 00 -> no score change, no beep.
- Drop rst_n mid OVER_TONE -> beep, score_bcd, hi_bcd and beep_busy go to 0 without waiting for a clock edge.
